// File: rtl/timer_pkg.sv
// Shared types for the countdown timer block.
//   timer_state_t : FSM encoding (idle / counting / frozen by pause)
package timer_pkg;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_RUN  = 2'd1,
    T_HOLD = 2'd2
  } timer_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up counter: sticks at all-ones instead of wrapping.
// Ports:
//   clk     : rising-edge clock
//   reset_n : async active-low reset, clears q
//   clr     : sync clear (wins over inc)
//   inc     : count enable
//   q       : current value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               q <= '0;
    else if (clr)               q <= '0;
    else if (inc && (q != '1))  q <= q + W'(1);
  end

endmodule

// File: rtl/countdown_timer.sv
// Programmable down-counting timer with one-shot / auto-reload modes.
// Ports:
//   clk, reset_n   : clock, async active-low reset
//   cfg_valid/ready: config handshake; ready whenever the timer is not running
//   cfg_load       : start / reload value (ticks per period)
//   cfg_periodic   : 1 = auto-reload, 0 = one-shot
//   start          : leave IDLE and begin counting (ignored if count is 0)
//   stop           : abort to IDLE, clear count
//   pause          : freeze count while high
//   tick           : prescaler enable; count moves only on tick
//   count          : current count (registered)
//   busy           : timer is not IDLE
//   tc             : one-cycle registered terminal-count pulse
//   tc_count       : saturating tc events since last accepted config
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TCW   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_load,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic [TCW-1:0]   tc_count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  timer_state_t     r_state, w_next;
  logic [WIDTH-1:0] r_count, r_reload;
  logic             r_periodic, r_tc;
  logic             w_cfg_acc, w_run_tick, w_tc_evt;

  // stop outranks everything, so it masks both config and counting
  assign w_cfg_acc  = cfg_valid & cfg_ready & ~stop;
  assign w_run_tick = (r_state == T_RUN) & ~stop & ~pause & tick;
  assign w_tc_evt   = w_run_tick & (r_count == ONE);

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= T_IDLE;
    else          r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    if (stop) begin
      w_next = T_IDLE;
    end else if (!w_cfg_acc) begin
      unique case (r_state)
        T_IDLE:  if (start && (r_count != '0)) w_next = T_RUN;
        T_RUN:   if (pause)                    w_next = T_HOLD;
                 else if (w_tc_evt && !r_periodic) w_next = T_IDLE;
        T_HOLD:  if (!pause)                   w_next = T_RUN;
        default: w_next = T_IDLE;
      endcase
    end
  end

  // outputs decoded from state
  always_comb begin
    cfg_ready = (r_state != T_RUN);
    busy      = (r_state != T_IDLE);
  end

  // count / reload datapath. A zero count in RUN (loaded as 0 while held)
  // just sits at 0: no wrap and no terminal event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= '0;
      r_reload   <= '0;
      r_periodic <= 1'b0;
      r_tc       <= 1'b0;
    end else begin
      r_tc <= w_tc_evt;
      if (stop) begin
        r_count <= '0;
      end else if (w_cfg_acc) begin
        r_count    <= cfg_load;
        r_reload   <= cfg_load;
        r_periodic <= cfg_periodic;
      end else if (w_run_tick) begin
        if (r_count == ONE)     r_count <= r_periodic ? r_reload : '0;
        else if (r_count > ONE) r_count <= r_count - ONE;
      end
    end
  end

  assign count = r_count;
  assign tc    = r_tc;

  sat_counter #(.W(TCW)) u_tc_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_cfg_acc),
    .inc     (w_tc_evt),
    .q       (tc_count)
  );

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;
  localparam int W   = 16;
  localparam int TCW = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           cfg_valid, cfg_ready, cfg_periodic;
  logic [W-1:0]   cfg_load, count;
  logic           start, stop, pause, tick, busy, tc;
  logic [TCW-1:0] tc_count;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(W), .TCW(TCW)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_load(cfg_load), .cfg_periodic(cfg_periodic), .start(start), .stop(stop),
    .pause(pause), .tick(tick), .count(count), .busy(busy), .tc(tc), .tc_count(tc_count)
  );

  typedef struct {
    logic cv; logic [W-1:0] ld; logic per, st, sp, pa, tk;
    logic [W-1:0] ec; logic eb, et; logic [TCW-1:0] en; logic er;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic cv, logic [W-1:0] ld, logic per, logic st, logic sp,
                              logic pa, logic tk, logic [W-1:0] ec, logic eb, logic et,
                              logic [TCW-1:0] en, logic er);
    vec_t v;
    v.cv = cv; v.ld = ld; v.per = per; v.st = st; v.sp = sp; v.pa = pa; v.tk = tk;
    v.ec = ec; v.eb = eb; v.et = et; v.en = en; v.er = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // drive one cycle of inputs, queue the expectation, compare after the edge
  task automatic step(input vec_t v, input string nm);
    vec_t e;
    @(negedge clk);
    cfg_valid = v.cv; cfg_load = v.ld; cfg_periodic = v.per;
    start = v.st; stop = v.sp; pause = v.pa; tick = v.tk;
    sb.push_back(v);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({nm, ".count"},    count,     e.ec);
    chk({nm, ".busy"},     busy,      e.eb);
    chk({nm, ".tc"},       tc,        e.et);
    chk({nm, ".tc_count"}, tc_count,  e.en);
    chk({nm, ".ready"},    cfg_ready, e.er);
  endtask

  initial begin : main
    int k;
    int last_tc;
    vec_t v;

    reset_n = 1'b0; cfg_valid = 0; cfg_load = '0; cfg_periodic = 0;
    start = 0; stop = 0; pause = 0; tick = 0;
    #2;
    chk("rst.count", count, 0);  chk("rst.busy", busy, 0);  chk("rst.tc", tc, 0);
    chk("rst.tcc", tc_count, 0); chk("rst.ready", cfg_ready, 1);
    @(negedge clk); reset_n = 1'b1;

    // one-shot 3: sequence 3,2,1,0 with tc alongside 0
    //           cv ld per st sp pa tk   cnt busy tc tcc rdy
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0,  3, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1,  3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1));
    // pause / cfg in HOLD / stop beats cfg
    tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0,  5, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,  5, 1, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1,  5, 1, 0, 0, 1));
    tbl.push_back(mk(1, 9, 0, 0, 0, 1, 1,  9, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  9, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  8, 1, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 1, 0, 1,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1,  0, 0, 0, 0, 1));  // start at count 0 ignored
    // cfg during RUN is refused
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0,  3, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,  3, 1, 0, 0, 0));
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0,  3, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 1));
    // periodic reload=1: tc every tick, tc_count saturates at 3
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 1, 1, (i < 3) ? TCW'(i + 1) : TCW'(3), 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 3, 1));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // periodic reload=4, tick on every 2nd cycle: tc every 8 cycles
    step(mk(1, 4, 1, 0, 0, 0, 0,  4, 0, 0, 0, 1), "per.cfg");
    step(mk(0, 0, 0, 1, 0, 0, 0,  4, 1, 0, 0, 0), "per.start");
    k = 0; last_tc = -1;
    for (int c = 0; c < 24; c++) begin
      logic tk;
      tk = (c % 2 == 1);
      if (tk) k++;
      v = mk(0, 0, 0, 0, 0, 0, tk, (k % 4 == 0) ? W'(4) : W'(4 - k % 4), 1,
             tk && (k % 4 == 0), (k / 4 > 3) ? TCW'(3) : TCW'(k / 4), 0);
      step(v, $sformatf("per.c%0d", c));
      if (tc === 1'b1) begin
        if (last_tc >= 0) chk("per.gap", c - last_tc, 8);
        last_tc = c;
      end
    end
    chk("per.last_tc", last_tc, 23);
    step(mk(0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 3, 1), "per.stop");

    // async reset mid-RUN, checked between clock edges
    step(mk(1, 10, 0, 0, 0, 0, 0, 10, 0, 0, 0, 1), "rr.cfg");
    step(mk(0, 0, 0, 1, 0, 0, 0,  10, 1, 0, 0, 0), "rr.start");
    step(mk(0, 0, 0, 0, 0, 0, 1,   9, 1, 0, 0, 0), "rr.t1");
    step(mk(0, 0, 0, 0, 0, 0, 1,   8, 1, 0, 0, 0), "rr.t2");
    #2 reset_n = 1'b0;
    #1;
    chk("rr.count", count, 0);  chk("rr.busy", busy, 0);  chk("rr.tc", tc, 0);
    chk("rr.tcc", tc_count, 0); chk("rr.ready", cfg_ready, 1);
    chk("sb.empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
